// File: rtl/pipe_feeder_pkg.sv
// rtl/pipe_feeder_pkg.sv - shared game constants, column FSM encoding and height helpers
package pipe_feeder_pkg;

    typedef enum logic [1:0] {
        ST_LEAD  = 2'd0,
        ST_SPACE = 2'd1,
        ST_PIPE  = 2'd2
    } feed_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          GAP_SIZE  = 12;
    localparam int          H_MIN     = 8;
    localparam int          H_MAX     = 60;
    localparam int          COL_W     = 7;

    // Raw values above this fold back down so the gap top never leaves the playfield.
    localparam int          RAW_FOLD  = H_MAX - H_MIN;

    // Gap bottom height from the low six LFSR bits: 0..52 -> 8..60, 53..63 -> 29..39.
    function automatic logic [COL_W-1:0] height_of(input logic [15:0] l);
        logic [COL_W-1:0] raw;
        raw = {1'b0, l[5:0]};
        if (raw <= COL_W'(RAW_FOLD)) begin
            return raw + COL_W'(H_MIN);
        end
        return raw - 7'd24;
    endfunction

    // Space length: minimum plus a 0..3 jitter taken from LFSR bits 9:8.
    function automatic logic [5:0] space_of(input logic [15:0] l, input int space_min);
        return 6'(space_min) + {4'b0000, l[9:8]};
    endfunction

endpackage

// File: rtl/pipe_feeder_lfsr16.sv
// rtl/pipe_feeder_lfsr16.sv - 16-bit right-shift Galois LFSR with load and step enable
module lfsr16
    import pipe_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step,
    output logic [15:0] value
);

    // Load wins over step so a restart always lands exactly on the seed.
    always_ff @(posedge clk) begin
        if (load) begin
            value <= load_value;
        end else if (step) begin
            value <= value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);
        end
    end

endmodule

// File: rtl/pipe_feeder.sv
// rtl/pipe_feeder.sv - pseudo-random pipe column generator feeding the scrolling datapath
module pipe_feeder
    import pipe_feeder_pkg::*;
#(
    parameter int          PIPE_W    = 2,
    parameter int          SPACE_MIN = 6,
    parameter int          LEAD_IN   = 8,
    parameter logic [15:0] SEED      = 16'hACE1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             col_req,
    output logic             col_valid,
    output logic [COL_W-1:0] col_data,
    output logic [7:0]       pipe_count
);

    // An all-zero Galois LFSR would lock up, so a zero seed is nudged to 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    feed_state_t      state, state_n;
    logic [5:0]       cnt, cnt_n;
    logic [COL_W-1:0] h_reg, h_n;
    logic [COL_W-1:0] col_data_n;
    logic             col_valid_n;
    logic [7:0]       pipe_count_n;
    logic [15:0]      lfsr;
    logic             init;
    logic             accept;

    assign init   = reset | restart;
    assign accept = col_req & ~init;

    lfsr16 u_lfsr (
        .clk        (clk),
        .load       (init),
        .load_value (SEED_EFF),
        .step       (accept),
        .value      (lfsr)
    );

    // Register the FSM, counter, latched height and column outputs.
    always_ff @(posedge clk) begin
        state      <= state_n;
        cnt        <= cnt_n;
        h_reg      <= h_n;
        col_data   <= col_data_n;
        col_valid  <= col_valid_n;
        pipe_count <= pipe_count_n;
    end

    // Next-state and column value; the height is taken on the first pipe column,
    // i.e. from the LFSR as it stood after the request that entered PIPE.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        h_n          = h_reg;
        col_data_n   = col_data;
        col_valid_n  = 1'b0;
        pipe_count_n = pipe_count;

        if (init) begin
            state_n      = ST_LEAD;
            cnt_n        = 6'(LEAD_IN);
            h_n          = '0;
            col_data_n   = '0;
            pipe_count_n = 8'd0;
        end else if (accept) begin
            col_valid_n = 1'b1;
            case (state)
                ST_PIPE: begin
                    if (cnt == 6'(PIPE_W)) begin
                        h_n        = height_of(lfsr);
                        col_data_n = height_of(lfsr);
                    end else begin
                        col_data_n = h_reg;
                    end
                    if (cnt <= 6'd1) begin
                        pipe_count_n = pipe_count + 8'd1;
                        state_n      = ST_SPACE;
                        cnt_n        = space_of(lfsr, SPACE_MIN);
                    end else begin
                        cnt_n = cnt - 6'd1;
                    end
                end
                default: begin
                    col_data_n = '0;
                    if (cnt <= 6'd1) begin
                        state_n = ST_PIPE;
                        cnt_n   = 6'(PIPE_W);
                    end else begin
                        cnt_n = cnt - 6'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_feeder.sv
// tb/tb_pipe_feeder.sv - directed-vector bench for pipe_feeder
module tb_pipe_feeder;

    logic clk = 1'b0;
    logic reset;
    logic restart;
    logic col_req;

    logic       v_main, v_z, v_a, v_b, v_c, v_d;
    logic [6:0] d_main, d_z, d_a, d_b, d_c, d_d;
    logic [7:0] pc_main, pc_z, pc_a, pc_b, pc_c, pc_d;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_feeder #(.SEED(16'h0001)) u_main (
        .clk(clk), .reset(reset), .restart(restart), .col_req(col_req),
        .col_valid(v_main), .col_data(d_main), .pipe_count(pc_main));

    pipe_feeder #(.SEED(16'h0000)) u_zero (
        .clk(clk), .reset(reset), .restart(restart), .col_req(col_req),
        .col_valid(v_z), .col_data(d_z), .pipe_count(pc_z));

    // LEAD_IN=1: the pipe height comes from SEED stepped once (SEED>>1 for even seeds).
    pipe_feeder #(.LEAD_IN(1), .SEED(16'h0078)) u_raw60 (
        .clk(clk), .reset(reset), .restart(restart), .col_req(col_req),
        .col_valid(v_a), .col_data(d_a), .pipe_count(pc_a));

    pipe_feeder #(.LEAD_IN(1), .SEED(16'h0068)) u_raw52 (
        .clk(clk), .reset(reset), .restart(restart), .col_req(col_req),
        .col_valid(v_b), .col_data(d_b), .pipe_count(pc_b));

    pipe_feeder #(.LEAD_IN(1), .SEED(16'h0080)) u_raw0 (
        .clk(clk), .reset(reset), .restart(restart), .col_req(col_req),
        .col_valid(v_c), .col_data(d_c), .pipe_count(pc_c));

    pipe_feeder #(.LEAD_IN(1), .SEED(16'h006A)) u_raw53 (
        .clk(clk), .reset(reset), .restart(restart), .col_req(col_req),
        .col_valid(v_d), .col_data(d_d), .pipe_count(pc_d));

    // Hand-computed: from 16'h0001 the LFSR is 16'h0168 after 8 steps (raw 40 -> 48),
    // bits 9:8 are 0 at the pipe end (space 6), and 16'h7C41 after 16 steps (raw 1 -> 9).
    logic [6:0] exp_main [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 48, 48, 0, 0, 0, 0, 0, 0, 9, 9};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One isolated request; outputs are sampled on the falling edge after acceptance.
    task automatic do_req();
        @(negedge clk);
        col_req = 1'b1;
        @(negedge clk);
        col_req = 1'b0;
    endtask

    int   run_len, gap_len, exp_pc, range_bad, run_bad, gap_bad, pc_bad, valid_cnt;
    bit   wrapped, seen_pipe;
    logic [6:0] cur_h;

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        col_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", v_main, 0);
        check("rst_data", d_main, 0);
        check("rst_pcount", pc_main, 0);
        reset = 1'b0;

        // Directed run from seed 1, mirrored by the zero-seed instance.
        for (int i = 0; i < 18; i++) begin
            do_req();
            check($sformatf("main_valid[%0d]", i + 1), v_main, 1);
            check($sformatf("main_data[%0d]", i + 1), d_main, exp_main[i]);
            check($sformatf("zero_seed_data[%0d]", i + 1), d_z, exp_main[i]);
            if (i == 0) begin
                check("raw60_lead", d_a, 0);
            end
            if (i == 1) begin
                check("raw60_h", d_a, 36);
                check("raw52_h", d_b, 60);
                check("raw0_h", d_c, 8);
                check("raw53_h", d_d, 29);
            end
            if (i == 8)  check("pcount_req9", pc_main, 0);
            if (i == 9)  check("pcount_req10", pc_main, 1);
            if (i == 17) check("pcount_req18", pc_main, 2);
            @(negedge clk);
            check($sformatf("valid_pulse[%0d]", i + 1), v_main, 0);
            check($sformatf("data_hold[%0d]", i + 1), d_main, exp_main[i]);
        end

        // Restart and request together: restart wins, then a fresh sequence.
        @(negedge clk);
        restart = 1'b1;
        col_req = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        col_req = 1'b0;
        check("restart_valid", v_main, 0);
        check("restart_data", d_main, 0);
        check("restart_pcount", pc_main, 0);
        for (int i = 0; i < 9; i++) begin
            do_req();
            check($sformatf("after_restart[%0d]", i + 1), d_main, exp_main[i]);
        end

        // Now mid-pipe: reset with a request pending must drop it.
        @(negedge clk);
        reset   = 1'b1;
        col_req = 1'b1;
        @(negedge clk);
        col_req = 1'b0;
        check("midpipe_rst_valid", v_main, 0);
        check("midpipe_rst_data", d_main, 0);
        check("midpipe_rst_pcount", pc_main, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_req();
            check($sformatf("after_reset[%0d]", i + 1), d_main, exp_main[i]);
        end
        check("after_reset_pcount", pc_main, 1);

        // Back-to-back requests; pipes, gaps and pipe_count judged from the column stream.
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart   = 1'b0;
        col_req   = 1'b1;
        run_len   = 0;
        gap_len   = 0;
        exp_pc    = 0;
        range_bad = 0;
        run_bad   = 0;
        gap_bad   = 0;
        pc_bad    = 0;
        valid_cnt = 0;
        wrapped   = 1'b0;
        seen_pipe = 1'b0;
        cur_h     = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 2999) col_req = 1'b0;
            if (v_main === 1'b1) valid_cnt++;
            if (d_main != 0) begin
                if (d_main < 8 || d_main > 60) range_bad++;
                if (run_len == 0) begin
                    if (seen_pipe && (gap_len < 6 || gap_len > 9)) gap_bad++;
                    if (!seen_pipe && gap_len != 8) gap_bad++;
                    cur_h = d_main;
                end else if (d_main != cur_h) begin
                    run_bad++;
                end
                run_len++;
                gap_len = 0;
                if (run_len == 2) begin
                    exp_pc++;
                    run_len   = 0;
                    seen_pipe = 1'b1;
                end
            end else begin
                if (run_len != 0) run_bad++;
                run_len = 0;
                gap_len++;
            end
            if (pc_main != 8'(exp_pc)) pc_bad++;
            if (exp_pc >= 256 && pc_main == 8'(exp_pc)) wrapped = 1'b1;
        end
        check("bb_valid_count", valid_cnt, 3000);
        check("bb_height_range", range_bad, 0);
        check("bb_pipe_width", run_bad, 0);
        check("bb_space_len", gap_bad, 0);
        check("bb_pcount_track", pc_bad, 0);
        check("bb_pcount_wrapped", wrapped, 1);
        @(negedge clk);
        check("bb_valid_idle", v_main, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
